cube_frame_sequencer: RTL
=========================

CUBE_FRAME_SEQUENCER -- requirements
Module: cube_frame_sequencer

Interface
REQ-001 SHALL have parameter STOP_HOLD, default 4096, meaning the cycles frm_stop is held after the final frame; the value must exceed one layer drive time.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port run, input, 1, level request to play frames.
REQ-005 SHALL have port dwell, input, 8, number of displays per frame; value 0 is treated as 1.
REQ-006 SHALL have port wr_en, input, 1, write strobe into the back buffer.
REQ-007 SHALL have port wr_addr, input, 6, back-buffer byte address {layer,latch}.
REQ-008 SHALL have port wr_data, input, 8, write byte.
REQ-009 SHALL have port swap_req, input, 1, one-cycle request to swap front and back buffers.
REQ-010 SHALL have port swap_ack, output, 1, one-cycle pulse when the swap takes effect.
REQ-011 SHALL have port frm_addr, input, 6, byte address from the single-frame driver.
REQ-012 SHALL have port frm_done, input, 1, frame-done level from the driver.
REQ-013 SHALL have port frm_start, output, 1, driver start pulse.
REQ-014 SHALL have port frm_stop, output, 1, driver stop level.
REQ-015 SHALL have port frm_data, output, 8, front-buffer byte at frm_addr.
REQ-016 SHALL have port front_sel, output, 1, index of the buffer currently displayed.
REQ-017 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-018 SHALL have port frame_tick, output, 1, one-cycle pulse per completed displayed frame.

Function
REQ-019 SHALL hold two 64x8 banks; frm_data = bank[front_sel][frm_addr], combinational, zero latency.
REQ-020 SHALL on wr_en write wr_data to bank[~front_sel][wr_addr] the next edge; a write in the swap cycle targets the pre-swap back bank.
REQ-021 SHALL implement FSM states IDLE, START, RUN, DRAIN, HOLD.
REQ-022 SHALL transition IDLE->START when run=1; START asserts frm_start for exactly one cycle, then goes to RUN.
REQ-023 SHALL detect the frm_done rising edge (done_evt); each done_evt pulses frame_tick one cycle later.
REQ-024 SHALL in RUN increment an 8-bit dwell counter on done_evt; when the count reaches max(dwell,1), a boundary occurs, the counter clears and dwell is resampled.
REQ-025 SHALL register swap_req into a pending flag; at a boundary with pending=1, toggle front_sel, pulse swap_ack and clear pending in the same edge.
REQ-026 SHALL not perform the swap in the cycle where swap_req arrives together with a boundary and pending=0; that swap waits for the next boundary.
REQ-027 SHALL in IDLE perform a pending swap on the cycle after pending sets.
REQ-028 SHALL ignore swap_req while pending=1; no queueing of more than one swap.
REQ-029 SHALL on run=0 in RUN go to DRAIN; DRAIN drives frm_stop=1 and keeps counting frames and swapping as in RUN.
REQ-030 SHALL in DRAIN on done_evt go to HOLD; HOLD keeps frm_stop=1 for STOP_HOLD cycles, then goes to IDLE with frm_stop=0.
REQ-031 SHALL ignore run changes in HOLD; run=1 on HOLD exit causes IDLE->START next cycle.
REQ-032 SHALL treat run=1 returning during DRAIN as a return to RUN with frm_stop=0.

Reset
REQ-033 SHALL on rst_n=0 set state to IDLE, front_sel to 0, pending to 0, all counters to 0, and frm_start, frm_stop, swap_ack, frame_tick and busy to 0.
REQ-034 SHALL not reset bank contents.
REQ-035 SHALL, when reset is applied mid-frame, abort with no swap_ack.

Structure
REQ-036 SHALL place the state enum, ADDR_W=6, DATA_W=8 and the STOP_HOLD default in the shared package cube_pkg.
REQ-037 SHALL place both banks and their write/read ports in one sub-module, cube_frame_buffer.

Verification
REQ-038 SHALL verify reset and start: reset, then run=1 -> frm_start high exactly 1 cycle two edges later, busy=1, front_sel=0.
REQ-039 SHALL verify read path: write 8'hA5 to back addr 6'd9, swap in IDLE -> swap_ack pulse, front_sel=1, and frm_addr=9 gives frm_data=8'hA5 the same cycle.
REQ-040 SHALL verify dwell: dwell=3 with swap pending -> swap_ack exactly on the 3rd done_evt; dwell=0 -> swap on the 1st.
REQ-041 SHALL verify a simultaneous event: swap_req in the boundary cycle with pending=0 -> no swap then, swap at the next boundary.
REQ-042 SHALL verify stop: run=0 mid-frame -> frm_stop=1, on done_evt HOLD lasts STOP_HOLD cycles, then IDLE with busy=0.
REQ-043 SHALL verify mid-frame reset: rst_n=0 with swap pending -> pending cleared, front_sel=0, no swap_ack.

Source files
------------

// File: rtl/cube_pkg.sv
// ---------------------------------------------------------------------------
// cube_pkg
// Shared definitions for the LED-cube frame sequencer:
//   - ADDR_W / DATA_W : frame byte address ({layer,latch}) and data widths
//   - DEPTH           : bytes per frame bank
//   - CNT_W           : width of the dwell counter and the dwell input
//   - STOP_HOLD_DEF   : default cycles the driver stop level is held after
//                       the final frame
//   - state_t         : sequencer FSM states
//   - dwell_target()  : maps the dwell setting to the number of displays per
//                       frame (a setting of 0 behaves like 1)
// ---------------------------------------------------------------------------
package cube_pkg;

    localparam int ADDR_W        = 6;
    localparam int DATA_W        = 8;
    localparam int DEPTH         = 1 << ADDR_W;
    localparam int CNT_W         = 8;
    localparam int STOP_HOLD_DEF = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    function automatic logic [CNT_W-1:0] dwell_target(input logic [CNT_W-1:0] setting);
        return (setting == '0) ? CNT_W'(1) : setting;
    endfunction

endpackage

// File: rtl/cube_frame_buffer.sv
// ---------------------------------------------------------------------------
// cube_frame_buffer
// Double-buffered frame store: two DEPTH x DATA_W banks. The bank selected by
// front_sel is displayed through a combinational read port; the other bank
// (the back buffer) takes writes.
//
// Ports
//   clk        in   rising-edge clock for the write port
//   front_sel  in   index of the displayed bank; writes go to the other bank
//   wr_en      in   write strobe into the back bank
//   wr_addr    in   back-bank byte address
//   wr_data    in   byte to write
//   rd_addr    in   front-bank byte address
//   rd_data    out  front-bank byte at rd_addr, zero latency
// ---------------------------------------------------------------------------
module cube_frame_buffer
    import cube_pkg::*;
(
    input  logic              clk,
    input  logic              front_sel,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] bank0 [DEPTH];
    logic [DATA_W-1:0] bank1 [DEPTH];

    // NOTE: the banks have no reset; clearing storage would need a per-word
    // reset path and frame contents are always rewritten before display.
    // The write uses front_sel as it stood before the edge, so a write in the
    // same cycle as a swap lands in the bank that was the back buffer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (front_sel) begin
                bank0[wr_addr] <= wr_data;
            end else begin
                bank1[wr_addr] <= wr_data;
            end
        end
    end

    assign rd_data = front_sel ? bank1[rd_addr] : bank0[rd_addr];

endmodule

// File: rtl/cube_frame_sequencer.sv
// ---------------------------------------------------------------------------
// cube_frame_sequencer
// Plays double-buffered frames through a single-frame layer driver. Each
// frame is shown 'dwell' times (0 behaves as 1); a requested buffer swap
// takes effect only on a frame boundary, or at once while idle. Dropping
// 'run' lets the current frame finish, then holds the driver stop level for
// STOP_HOLD cycles before returning to idle.
//
// Parameters
//   STOP_HOLD   cycles frm_stop stays high after the final frame; must be
//               longer than one layer drive time
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   run         in   level request to play frames
//   dwell       in   displays per frame (0 treated as 1)
//   wr_en       in   back-buffer write strobe
//   wr_addr     in   back-buffer byte address {layer,latch}
//   wr_data     in   back-buffer write byte
//   swap_req    in   one-cycle request to swap front and back buffers
//   swap_ack    out  one-cycle pulse when the swap takes effect
//   frm_addr    in   byte address from the frame driver
//   frm_done    in   frame-done level from the frame driver
//   frm_start   out  driver start pulse
//   frm_stop    out  driver stop level
//   frm_data    out  front-buffer byte at frm_addr (combinational)
//   front_sel   out  index of the displayed buffer
//   busy        out  high whenever the sequencer is not idle
//   frame_tick  out  one-cycle pulse per completed displayed frame
// ---------------------------------------------------------------------------
module cube_frame_sequencer
    import cube_pkg::*;
#(
    parameter int unsigned STOP_HOLD = STOP_HOLD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [CNT_W-1:0]  dwell,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              swap_req,
    output logic              swap_ack,
    input  logic [ADDR_W-1:0] frm_addr,
    input  logic              frm_done,
    output logic              frm_start,
    output logic              frm_stop,
    output logic [DATA_W-1:0] frm_data,
    output logic              front_sel,
    output logic              busy,
    output logic              frame_tick
);

    // Wide enough to hold STOP_HOLD itself.
    localparam int HOLD_W = $clog2(STOP_HOLD) + 1;

    state_t            state;
    state_t            state_nxt;

    logic              done_q;
    logic              done_evt;
    logic              playing;
    logic              boundary;
    logic              do_swap;
    logic              hold_last;
    logic              start_pulse;
    logic              pending;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  dwell_q;
    logic [HOLD_W-1:0] hold_cnt;

    // -----------------------------------------------------------------------
    // Frame store
    // -----------------------------------------------------------------------
    cube_frame_buffer u_buffer (
        .clk       (clk),
        .front_sel (front_sel),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (frm_addr),
        .rd_data   (frm_data)
    );

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    // The driver reports completion as a level; only its rising edge counts.
    assign done_evt  = frm_done & ~done_q;
    assign playing   = (state == ST_RUN) || (state == ST_DRAIN);

    // frame_cnt never exceeds target-1, so the increment cannot wrap.
    assign boundary  = playing && done_evt &&
                       ((frame_cnt + CNT_W'(1)) >= dwell_target(dwell_q));

    // Uses the registered pending flag: a request arriving in a boundary
    // cycle is only captured here and waits for the next boundary.
    assign do_swap   = pending && ((state == ST_IDLE) || boundary);

    assign hold_last = (hold_cnt == HOLD_W'(STOP_HOLD - 1));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: reset is synchronous, so rst_n is tested inside the clocked block
    // and stays out of the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (run) state_nxt = ST_START;
            ST_START: state_nxt = ST_RUN;
            ST_RUN:   if (!run) state_nxt = ST_DRAIN;
            // A finished frame wins over run returning: the driver has already
            // been told to stop, so that frame was the final one.
            ST_DRAIN: begin
                if (done_evt) begin
                    state_nxt = ST_HOLD;
                end else if (run) begin
                    state_nxt = ST_RUN;
                end
            end
            // run is ignored here; if it is high at exit, IDLE starts again
            // on the following cycle.
            ST_HOLD:  if (hold_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output decode
    // -----------------------------------------------------------------------
    always_comb begin
        start_pulse = (state == ST_START);
        frm_stop    = (state == ST_DRAIN) || (state == ST_HOLD);
        busy        = (state != ST_IDLE);
    end

    // -----------------------------------------------------------------------
    // Datapath: counters, swap handshake, registered pulses
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q     <= 1'b0;
            frm_start  <= 1'b0;
            frame_tick <= 1'b0;
            swap_ack   <= 1'b0;
            front_sel  <= 1'b0;
            pending    <= 1'b0;
            frame_cnt  <= '0;
            dwell_q    <= '0;
            hold_cnt   <= '0;
        end else begin
            done_q     <= frm_done;
            frm_start  <= start_pulse;
            frame_tick <= playing && done_evt;
            swap_ack   <= do_swap;

            // Only one swap can be outstanding; further requests are dropped
            // until the pending one is taken.
            if (do_swap) begin
                front_sel <= ~front_sel;
                pending   <= 1'b0;
            end else if (swap_req) begin
                pending   <= 1'b1;
            end

            // Dwell is sampled when play starts and again at every boundary,
            // so a new setting never cuts a frame short.
            if (state == ST_START) begin
                frame_cnt <= '0;
                dwell_q   <= dwell;
            end else if (playing && done_evt) begin
                if (boundary) begin
                    frame_cnt <= '0;
                    dwell_q   <= dwell;
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end

            if ((state == ST_HOLD) && !hold_last) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule
